// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the system PLL reset and watches its lock output.
// The core is held in reset until lock has been stable for LOCK_STABLE cycles.
// The PLL is reset again if lock does not arrive within LOCK_TIMEOUT cycles.
// A loss of lock while running restarts the whole sequence.
// A pixel clock-enable pulse is produced every CE_DIV cycles while running.
// Optional macro PLL_LOCK_LOSS_CNT_EN adds a saturating lock-loss counter (lost_cnt).

module pll_lock_sequencer #(
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int PLL_RST_LEN  = 16,
    parameter int CE_DIV       = 4
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       locked_in,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ce_pix,
    output logic       ready
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lost_cnt
`endif
);

    // The shared counter is sized by the longest interval it must measure.
    localparam int MAX_AB  = (LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > PLL_RST_LEN) ? MAX_AB : PLL_RST_LEN;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_LEN - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CE_DIV - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             locked_meta;
    logic             locked_s;

    // Two-flop synchronizer bringing the asynchronous lock signal into clk_sys.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= locked_in;
            locked_s    <= locked_meta;
        end
    end

    // State register plus the shared interval counter, cleared on every state change.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PLL_RST;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == ST_RUN) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next-state decisions; lock status takes priority over an expiring count.
    always_comb begin
        state_next = state;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = ST_PLL_RST;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_next = ST_PLL_RST;
                end
            end
            default: state_next = ST_PLL_RST;
        endcase
    end

    // Pixel enable divider; a pulse is suppressed on the edge that leaves RUN.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            ce_pix <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            end else begin
                div <= '0;
            end
            ce_pix <= (state == ST_RUN) && (state_next == ST_RUN) && (div == DIV_LAST);
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    // Saturating count of lock losses seen while running; only rst_n clears it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= 8'd0;
        end else if (state == ST_RUN && !locked_s && lost_cnt != 8'hFF) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end
`endif

    assign pll_rst   = (state == ST_PLL_RST);
    assign sys_reset = (state != ST_RUN);
    assign ready     = (state == ST_RUN);

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Consumer-side companion to the system PLL: drives the PLL's reset input and consumes its `locked` output, producing a clean core reset and a pixel clock-enable on the system clock. Holds the core in reset until lock has been stable for a programmable time, re-resets the PLL on lock timeout, and restarts the sequence on lock loss. Sits between the PLL instance and the core's reset/enable distribution.

## Interface
- `LOCK_STABLE`, 1024: consecutive synchronized-locked cycles required before release (≥2).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before re-resetting the PLL (≥2).
- `PLL_RST_LEN`, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- `CE_DIV`, 4: `ce_pix` period in `clk_sys` cycles (≥2; 4 gives 25 MHz from 100 MHz).

- `clk_sys` in 1: system clock, the PLL's fast output.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `locked_in` in 1: PLL lock, asynchronous to `clk_sys`.
- `pll_rst` out 1: PLL reset request, active high.
- `sys_reset` out 1: core reset, active high.
- `ce_pix` out 1: one-cycle pixel clock-enable pulse.
- `ready` out 1: high while in RUN.
- `lost_cnt` out 8: lock-loss event count. Present only with the macro.

## Operation
- `locked_in` passes through a 2-FF synchronizer to give `locked_s`. All decisions use `locked_s`.
- FSM states: PLL_RST, WAIT_LOCK, STABLE, RUN. One shared cycle counter `cnt`, cleared on every state change.
  - PLL_RST: `pll_rst`=1. After `PLL_RST_LEN` cycles, go to WAIT_LOCK.
  - WAIT_LOCK: if `locked_s`=1, go to STABLE. Otherwise, when `cnt` reaches `LOCK_TIMEOUT`-1, go to PLL_RST.
  - STABLE: if `locked_s`=0, go to WAIT_LOCK (counter cleared, timeout restarts). After `LOCK_STABLE` consecutive high cycles, go to RUN.
  - RUN: if `locked_s`=0, go to PLL_RST and increment `lost_cnt` (if compiled).
- Moore outputs decoded from the state register:
  - `pll_rst` = (state==PLL_RST)
  - `sys_reset` = (state!=RUN)
  - `ready` = (state==RUN)
- `ce_pix` divider counts 0..`CE_DIV`-1 only in RUN and is held at 0 elsewhere. `ce_pix` is registered and pulses high for one cycle each time the divider wraps. No pulse outside RUN.
- `lost_cnt` saturates at 255 and is never cleared except by `rst_n`.
- Counter widths come from `$clog2` of the largest parameter. Comparisons use exact equality to the parameter minus 1.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state=PLL_RST, synchronizer=0, `cnt`=0, divider=0
  - `pll_rst`=1, `sys_reset`=1, `ce_pix`=0, `ready`=0, `lost_cnt`=0
- Reset deassertion mid-sequence always restarts from PLL_RST.
- `locked_in` rise to `locked_s` takes 2 cycles. WAIT_LOCK→STABLE happens on the next edge.
- Release latency from `locked_s` rise: 1 + `LOCK_STABLE` cycles to the first RUN cycle. `sys_reset` is 0 in that first RUN cycle.
- First `ce_pix` pulse arrives `CE_DIV` cycles after entering RUN.
- Lock drop in RUN: 2 cycles of sync, then the next edge enters PLL_RST. `sys_reset`=1 and `ce_pix`=0 from that cycle.
- A `locked_s` drop on the same cycle the STABLE count completes: the drop wins, and the FSM goes to WAIT_LOCK.
- A `locked_s` rise on the same cycle as the WAIT_LOCK timeout: lock wins, and the FSM goes to STABLE.

## Configuration
- `PLL_LOCK_LOSS_CNT_EN` defined: `lost_cnt` port and its saturating counter exist.
- `PLL_LOCK_LOSS_CNT_EN` undefined: the port and logic are absent. FSM behaviour is otherwise identical.

## Test plan
Bench parameters: `LOCK_STABLE`=8, `LOCK_TIMEOUT`=32, `PLL_RST_LEN`=4, `CE_DIV`=4.
- Power-up, `locked_in` held 0 → `pll_rst` high for 4 cycles, low for 32, high again for 4, repeating. `sys_reset` stays 1 and `ce_pix` stays 0.
- `locked_in` rises during WAIT_LOCK and stays high → `sys_reset` falls exactly 2+1+8 cycles after the rise. `ready`=1. `ce_pix` pulses every 4th cycle, first on cycle 4 of RUN.
- `locked_in` glitches low for 3 cycles during STABLE → return to WAIT_LOCK. The STABLE count restarts, and release happens 8 cycles after the second `locked_s` rise plus 1.
- `locked_in` drops in RUN → 3 cycles later `pll_rst`=1, `sys_reset`=1, `ce_pix`=0. `lost_cnt` goes 0→1. Repeat 300 times → `lost_cnt`=255.
- `rst_n` pulsed low during RUN → all outputs take their reset values immediately, without a clock edge. Sequence restarts at PLL_RST.
- Build without `PLL_LOCK_LOSS_CNT_EN` → the same scenarios pass with no `lost_cnt` port.
